// File: rtl/pipe_pkg.sv
// Shared definitions for handshake pipeline stages: state encoding and occupancy width.
package pipe_pkg;

    localparam int unsigned OCC_W = 2;

    // Encoding equals the number of live entries in each state.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FULL    = 2'd1,
        ST_SKIDDED = 2'd2
    } stage_state_e;

endpackage

// File: rtl/pipe_stage_hs_reg.sv
// Valid/ready pipeline register with optional two-entry skid buffer, stall freeze and flush.
// The head entry always sits in main_q so out_data_o comes straight from a flop.
module pipe_stage_hs_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W         = 32,
    parameter bit                SKID           = 1'b1,
    parameter bit                CLEAR_ON_FLUSH = 1'b1,
    parameter logic [DATA_W-1:0] RESET_VAL      = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [OCC_W-1:0]  occupancy_o
);

    stage_state_e      state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q;
    logic              accept;
    logic              issue;

    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_data_o  = main_q;

    // With a skid slot in_ready depends only on state, so it is effectively registered.
    always_comb begin
        if (SKID) begin
            in_ready_o = (state_q != ST_SKIDDED) && !stall_i;
        end else begin
            in_ready_o = (!out_valid_o || out_ready_i) && !stall_i;
        end
    end

    assign accept = in_valid_i && in_ready_o;
    assign issue  = out_valid_o && out_ready_i && !stall_i;

    always_comb begin
        occupancy_o = '0;
        case (state_q)
            ST_EMPTY:   occupancy_o = 2'd0;
            ST_FULL:    occupancy_o = 2'd1;
            ST_SKIDDED: occupancy_o = 2'd2;
            default:    occupancy_o = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
            if (CLEAR_ON_FLUSH) begin
                main_d = RESET_VAL;
            end
        end else if (!stall_i) begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_FULL;
                        main_d  = in_data_i;
                    end
                end
                ST_FULL: begin
                    if (accept && issue) begin
                        main_d = in_data_i;
                    end else if (issue) begin
                        state_d = ST_EMPTY;
                    end else if (accept && SKID) begin
                        state_d = ST_SKIDDED;
                    end
                end
                ST_SKIDDED: begin
                    if (issue) begin
                        state_d = ST_FULL;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            main_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    generate
        if (SKID) begin : g_skid
            logic [DATA_W-1:0] skid_d;

            // Skid slot only captures when the head is occupied and not leaving.
            always_comb begin
                skid_d = skid_q;
                if (flush_i) begin
                    if (CLEAR_ON_FLUSH) begin
                        skid_d = RESET_VAL;
                    end
                end else if ((state_q == ST_FULL) && accept && !issue) begin
                    skid_d = in_data_i;
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    skid_q <= RESET_VAL;
                end else begin
                    skid_q <= skid_d;
                end
            end
        end else begin : g_no_skid
            assign skid_q = RESET_VAL;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_hs_reg.sv
// Scoreboard bench for pipe_stage_hs_reg: one skid instance and one single-register instance.
module tb_pipe_stage_hs_reg;

    localparam logic [31:0] RV1 = 32'hDEAD_BEEF;
    localparam logic [31:0] RV0 = 32'h0000_5A5A;

    logic        clk = 1'b0;
    logic        rst;

    logic        stall, flush, in_valid, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [1:0]  occ;

    logic        stall0, flush0, in_valid0, out_ready0;
    logic [31:0] in_data0;
    logic        in_ready0, out_valid0;
    logic [31:0] out_data0;
    logic [1:0]  occ0;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp0_q[$];

    always #5 clk = ~clk;

    pipe_stage_hs_reg #(
        .DATA_W(32), .SKID(1'b1), .CLEAR_ON_FLUSH(1'b1), .RESET_VAL(RV1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .occupancy_o(occ)
    );

    pipe_stage_hs_reg #(
        .DATA_W(32), .SKID(1'b0), .CLEAR_ON_FLUSH(1'b1), .RESET_VAL(RV0)
    ) dut0 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall0), .flush_i(flush0),
        .in_valid_i(in_valid0), .in_ready_o(in_ready0), .in_data_i(in_data0),
        .out_valid_o(out_valid0), .out_ready_i(out_ready0), .out_data_o(out_data0),
        .occupancy_o(occ0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: pop one expectation per handshake completed at the next edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !stall && !flush) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb1_unexpected: got %h expected none", out_data);
            end else begin
                check("sb1_out", out_data, exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("skid0_occ_max", {31'd0, (occ0 > 2'd1)}, 32'd0);
            if (out_valid0 && out_ready0 && !stall0 && !flush0) begin
                if (exp0_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb0_unexpected: got %h expected none", out_data0);
                end else begin
                    check("sb0_out", out_data0, exp0_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        stall = 0; flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
        stall0 = 0; flush0 = 0; in_valid0 = 0; out_ready0 = 0; in_data0 = '0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_occ", {30'd0, occ}, 32'd0);
        check("rst_out_data", out_data, RV1);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst0_out_data", out_data0, RV0);
        tick();
        tick();
        rst = 1'b0;

        // Streaming: one-cycle latency, occupancy stays at 1.
        out_ready = 1; in_valid = 1;
        for (int i = 1; i <= 8; i++) begin
            in_data = 32'(i);
            exp_q.push_back(32'(i));
            tick();
            check("stream_occ", {30'd0, occ}, 32'd1);
            check("stream_latency", out_data, 32'(i));
        end
        in_valid = 0;
        tick();
        check("stream_drain_occ", {30'd0, occ}, 32'd0);

        // Backpressure into the skid slot.
        out_ready = 0; in_valid = 1; in_data = 32'hA; exp_q.push_back(32'hA);
        tick();
        in_data = 32'hB; exp_q.push_back(32'hB);
        tick();
        in_valid = 0;
        check("bp_occ", {30'd0, occ}, 32'd2);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_head", out_data, 32'hA);
        out_ready = 1;
        tick();
        check("bp_second", out_data, 32'hB);
        tick();
        check("bp_empty", {31'd0, out_valid}, 32'd0);

        // Stall while SKIDDED: nothing moves even with both sides willing.
        out_ready = 0; in_valid = 1; in_data = 32'hA; exp_q.push_back(32'hA);
        tick();
        in_data = 32'hB; exp_q.push_back(32'hB);
        tick();
        stall = 1; out_ready = 1; in_data = 32'hEE;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
            check("stall_occ", {30'd0, occ}, 32'd2);
            check("stall_head", out_data, 32'hA);
        end
        stall = 0; in_valid = 0;
        tick();
        tick();
        check("stall_drain", {30'd0, occ}, 32'd0);

        // Flush beats stall and the same-cycle input; both held entries vanish.
        out_ready = 0; in_valid = 1; in_data = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        flush = 1; stall = 1; in_data = 32'hC;
        tick();
        flush = 0; stall = 0; in_valid = 0;
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_occ", {30'd0, occ}, 32'd0);
        check("flush_data", out_data, RV1);
        out_ready = 1;
        tick();
        tick();
        check("flush_still_empty", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-cycle while FULL.
        out_ready = 0; in_valid = 1; in_data = 32'h55;
        tick();
        in_valid = 0;
        check("areset_pre", out_data, 32'h55);
        #2 rst = 1'b1;
        #1;
        check("areset_valid", {31'd0, out_valid}, 32'd0);
        check("areset_data", out_data, RV1);
        check("areset_occ", {30'd0, occ}, 32'd0);
        check("areset_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        #2 rst = 1'b0;
        in_valid = 1; in_data = 32'h66; exp_q.push_back(32'h66);
        tick();
        in_valid = 0;
        check("post_reset_accept", out_data, 32'h66);
        out_ready = 1;
        tick();

        // Single-register variant: pass-through when downstream drains.
        out_ready0 = 0; in_valid0 = 1; in_data0 = 32'h1; exp0_q.push_back(32'h1);
        tick();
        check("skid0_full_not_ready", {31'd0, in_ready0}, 32'd0);
        in_data0 = 32'h2;
        tick();
        check("skid0_held", out_data0, 32'h1);
        out_ready0 = 1; exp0_q.push_back(32'h2);
        #1;
        check("skid0_ready_thru", {31'd0, in_ready0}, 32'd1);
        tick();
        in_valid0 = 0;
        check("skid0_next", out_data0, 32'h2);
        check("skid0_occ", {30'd0, occ0}, 32'd1);
        tick();
        check("skid0_empty", {31'd0, out_valid0}, 32'd0);
        tick();

        check("sb1_leftover", 32'(exp_q.size()), 32'd0);
        check("sb0_leftover", 32'(exp0_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/pipe_stage_hs_reg.md
PIPE_STAGE_HS_REG -- requirements
Module: pipe_stage_hs_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the packed stage payload.
REQ-002 SHALL have parameter SKID, default 1; 0 = single register, 1 = two-entry skid buffer with registered in_ready_o.
REQ-003 SHALL have parameter CLEAR_ON_FLUSH, default 1; 1 = payload registers load RESET_VAL on flush.
REQ-004 SHALL have parameter RESET_VAL, default all-zero DATA_W value, payload value after reset.
REQ-005 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port stall_i, input, 1, memory busywait; freezes all state.
REQ-008 SHALL have port flush_i, input, 1, synchronous kill of all held entries.
REQ-009 SHALL have port in_valid_i, input, 1, upstream payload valid.
REQ-010 SHALL have port in_ready_o, output, 1, stage can accept this cycle.
REQ-011 SHALL have port in_data_i, input, DATA_W, upstream payload.
REQ-012 SHALL have port out_valid_o, output, 1, out_data_o holds a live entry.
REQ-013 SHALL have port out_ready_i, input, 1, downstream can accept.
REQ-014 SHALL have port out_data_o, output, DATA_W, head entry payload, driven directly from a register.
REQ-015 SHALL have port occupancy_o, output, 2, number of live entries (0..2).

Function
REQ-016 SHALL define accept = in_valid_i & in_ready_o and issue = out_valid_o & out_ready_i & ~stall_i.
REQ-017 SHALL hold states EMPTY (0 entries), FULL (main only), SKIDDED (main+skid, SKID=1 only).
REQ-018 SHALL drive out_valid_o = (state != EMPTY) and occupancy_o = 0/1/2 for EMPTY/FULL/SKIDDED.
REQ-019 SHALL, with SKID=1, drive in_ready_o = (state != SKIDDED) & ~stall_i.
REQ-020 SHALL, with SKID=0, drive in_ready_o = (~out_valid_o | out_ready_i) & ~stall_i.
REQ-021 SHALL transition EMPTY -> FULL on accept, main <= in_data_i.
REQ-022 SHALL in FULL: accept&issue -> FULL, main <= in_data_i; issue only -> EMPTY, main holds value; accept only -> SKIDDED, skid <= in_data_i (SKID=0: accept only cannot occur).
REQ-023 SHALL in SKIDDED: issue -> FULL, main <= skid; otherwise hold.
REQ-024 SHALL preserve strict FIFO order; latency in_data_i to out_data_o is exactly 1 cycle when EMPTY or when FULL with issue.
REQ-025 SHALL, while stall_i=1 and flush_i=0, keep state, main and skid unchanged regardless of other inputs.
REQ-026 SHALL, on flush_i=1, go to EMPTY next edge, drop the same-cycle input, and (CLEAR_ON_FLUSH=1) load RESET_VAL into main and skid.
REQ-027 SHALL give flush_i priority over stall_i and over any accept or issue.
REQ-028 SHALL never drop or duplicate an entry: accepts minus issues equals occupancy change every non-flush cycle.

Reset
REQ-029 SHALL, while rst_i=1 (asynchronously, including mid-transfer), force state EMPTY, main=skid=RESET_VAL, out_valid_o=0, occupancy_o=0.
REQ-030 SHALL drive in_ready_o=1 during and after reset when stall_i=0 and resume acceptance on the first edge after rst_i falls.

Structure
REQ-031 SHALL take the state encoding (EMPTY/FULL/SKIDDED) and occupancy width constant from shared package pipe_pkg.
REQ-032 SHALL be one module; skid storage and logic generated only when SKID=1; no sub-module.

Verification
REQ-033 SHALL cover streaming: SKID=1, out_ready_i=1, 8 back-to-back inputs 0x1..0x8 -> out_data_o 0x1..0x8 one cycle later, occupancy_o constant 1.
REQ-034 SHALL cover backpressure: FULL with 0xA, out_ready_i=0, input 0xB -> occupancy_o=2, in_ready_o=0; out_ready_i=1 -> outputs 0xA then 0xB.
REQ-035 SHALL cover stall: SKIDDED with 0xA/0xB, stall_i=1 for 3 cycles with out_ready_i=1 -> no issue, in_ready_o=0, state and data unchanged.
REQ-036 SHALL cover flush+stall: SKIDDED, flush_i=1, stall_i=1, in_valid_i=1 with 0xC -> next cycle out_valid_o=0, occupancy_o=0, out_data_o=RESET_VAL, 0xC never emitted.
REQ-037 SHALL cover async reset: assert rst_i between edges while FULL with 0x55 -> out_valid_o=0 and out_data_o=RESET_VAL immediately, before next edge.
REQ-038 SHALL cover SKID=0: FULL with 0x1, out_ready_i=1, input 0x2 same cycle -> in_ready_o=1, out_data_o=0x2 next cycle, occupancy_o never exceeds 1.
